// File: rtl/framebuf_pkg.sv
// Shared types and constants for the OLED framebuffer controller.
package framebuf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam logic [7:0] CLEAR_VALUE_DEFAULT = 8'h00;

endpackage

// File: rtl/framebuf_ctrl_if.sv
// Signal bundle between framebuf_ctrl and its environment (writers, clear control, streamer, RAM).
interface framebuf_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  clear_start;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  wa_req;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_data;
    logic                  wa_ack;
    logic                  wb_req;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_ack;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [DATA_WIDTH-1:0] ram_read_data;

    // Environment side: writers, clear control, display streamer and the RAM read data.
    modport master (
        output clear_start, wa_req, wa_addr, wa_data, wb_req, wb_addr, wb_data,
               rd_req, rd_addr, ram_read_data,
        input  clear_busy, clear_done, wa_ack, wb_ack, rd_valid, rd_data,
               ram_write_en, ram_write_addr, ram_write_data, ram_read_addr
    );

    modport slave (
        input  clear_start, wa_req, wa_addr, wa_data, wb_req, wb_addr, wb_data,
               rd_req, rd_addr, ram_read_data,
        output clear_busy, clear_done, wa_ack, wb_ack, rd_valid, rd_data,
               ram_write_en, ram_write_addr, ram_write_data, ram_read_addr
    );

endinterface

// File: rtl/framebuf_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last grant so ties alternate.
module rr_arb2
    import framebuf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (enable_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == GNT_B) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (update_i && gnt_o[0]) begin
            last_d = GNT_A;
        end else if (update_i && gnt_o[1]) begin
            last_d = GNT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/framebuf_ctrl.sv
// Framebuffer controller: shares the RAM write port between the clear engine and writers A/B,
// and passes streamer reads through. Optional macro FRAMEBUF_CLEAR_ON_RESET_EN starts a sweep after reset.
//
// state | meaning
// IDLE  | arbitrating writers A/B, waiting for clear_start
// CLEAR | sweeping CLEAR_VALUE over every address, one per cycle
module framebuf_ctrl
    import framebuf_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 9,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(CLEAR_VALUE_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    framebuf_ctrl_if.slave  bus
);

    // Counter is one bit wider than the address so the terminal value never aliases address 0.
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    fb_state_t             state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wa_ack_q, wa_ack_d;
    logic                  wb_ack_q, wb_ack_d;
    logic                  rd_valid_q;
    logic                  start;
    logic                  arb_en;
    logic [1:0]            gnt;

`ifdef FRAMEBUF_CLEAR_ON_RESET_EN
    logic init_clr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_clr_q <= 1'b1;
        end else begin
            init_clr_q <= 1'b0;
        end
    end

    assign start = bus.clear_start | init_clr_q;
`else
    assign start = bus.clear_start;
`endif

    assign arb_en = (state_q == IDLE) && !start;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus.wb_req & ~wb_ack_q, bus.wa_req & ~wa_ack_q}),
        .enable_i (arb_en),
        .update_i (arb_en),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wa_ack_d = 1'b0;
        wb_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = {{ADDR_WIDTH{1'b0}}, 1'b1};
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = CLEAR_VALUE;
                    busy_d  = 1'b1;
                end else if (gnt[0]) begin
                    we_d     = 1'b1;
                    waddr_d  = bus.wa_addr;
                    wdata_d  = bus.wa_data;
                    wa_ack_d = 1'b1;
                end else if (gnt[1]) begin
                    we_d     = 1'b1;
                    waddr_d  = bus.wb_addr;
                    wdata_d  = bus.wb_data;
                    wb_ack_d = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == DEPTH) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = CLEAR_VALUE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wa_ack_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wa_ack_q   <= wa_ack_d;
            wb_ack_q   <= wb_ack_d;
            rd_valid_q <= bus.rd_req;
        end
    end

    assign bus.clear_busy     = busy_q;
    assign bus.clear_done     = done_q;
    assign bus.wa_ack         = wa_ack_q;
    assign bus.wb_ack         = wb_ack_q;
    assign bus.ram_write_en   = we_q;
    assign bus.ram_write_addr = waddr_q;
    assign bus.ram_write_data = wdata_q;
    assign bus.ram_read_addr  = bus.rd_addr;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = bus.ram_read_data;

endmodule

// File: tb/tb_framebuf_ctrl.sv
// Directed bench for framebuf_ctrl with a read-before-write RAM model attached to the RAM ports.
module tb_framebuf_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    framebuf_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus ();

    framebuf_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .CLEAR_VALUE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512] = '{default: 8'hFF};
    logic [7:0] ram_q = 8'h00;

    always @(posedge clk) begin
        ram_q <= mem[bus.ram_read_addr];
        if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_data;
    end
    assign bus.ram_read_data = ram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // {we, busy, done, wa_ack, wb_ack, rd_valid, addr[8:0], data[7:0]}
    function automatic logic [31:0] outs();
        return {9'd0, bus.ram_write_en, bus.clear_busy, bus.clear_done, bus.wa_ack,
                bus.wb_ack, bus.rd_valid, bus.ram_write_addr, bus.ram_write_data};
    endfunction

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            tick();
            seen = bus.clear_done;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        chk(tag, outs(), 32'd0);
        rst = 1'b0;
`ifdef FRAMEBUF_CLEAR_ON_RESET_EN
        tick();
        chk({tag, "_autoclr"}, {31'd0, bus.clear_busy}, 32'd1);
        wait_done({tag, "_autodone"});
`endif
    endtask

    task automatic write_a(input logic [8:0] a, input logic [7:0] d);
        bus.wa_req  = 1'b1;
        bus.wa_addr = a;
        bus.wa_data = d;
        tick();
        chk("write_a_ack", {bus.wa_ack, bus.ram_write_en, 5'd0, bus.ram_write_addr, bus.ram_write_data},
            {1'b1, 1'b1, 5'd0, a, d});
        bus.wa_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] old_1ff;
        logic       seen_busy;
        logic       seen_done;
        bus.clear_start = 1'b0;
        bus.wa_req = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
        bus.wb_req = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;

        // Two reset cycles, then a single write from A.
        tick();
        do_reset("reset_outs");
        bus.wa_req = 1'b1; bus.wa_addr = 9'h010; bus.wa_data = 8'hA5;
        tick();
        chk("a_first_grant", outs(), {9'd0, 6'b100100, 9'h010, 8'hA5});
        tick();
        chk("a_no_double_ack", {30'd0, bus.wa_ack, bus.ram_write_en}, 32'd0);
        bus.wa_req = 1'b0;
        tick();
        chk("a_idle_after", {30'd0, bus.wa_ack, bus.ram_write_en}, 32'd0);

        // Both writers held: alternation A,B,A,B from reset.
        do_reset("reset_rr");
        bus.wa_req = 1'b1; bus.wa_addr = 9'h020; bus.wa_data = 8'h11;
        bus.wb_req = 1'b1; bus.wb_addr = 9'h021; bus.wb_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) chk("rr_grant_a", outs(), {9'd0, 6'b100100, 9'h020, 8'h11});
            else            chk("rr_grant_b", outs(), {9'd0, 6'b100010, 9'h021, 8'h22});
        end
        bus.wa_req = 1'b0; bus.wb_req = 1'b0;
        tick();
        chk("rr_stop", {31'd0, bus.ram_write_en}, 32'd0);

        // Read-before-write collision at 0x1FF, then re-read.
`ifdef FRAMEBUF_CLEAR_ON_RESET_EN
        old_1ff = 8'h00;
`else
        old_1ff = 8'hFF;
`endif
        bus.wa_req = 1'b1; bus.wa_addr = 9'h1FF; bus.wa_data = 8'h3C;
        tick();
        chk("rw_write_issued", outs(), {9'd0, 6'b100100, 9'h1FF, 8'h3C});
        bus.wa_req = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 9'h1FF;
        #1;
        chk("rd_addr_passthru", {23'd0, bus.ram_read_addr}, 32'h1FF);
        tick();
        chk("rd_old_data", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, old_1ff});
        tick();
        chk("rd_new_data", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h3C});
        bus.rd_req = 1'b0;
        tick();
        chk("rd_valid_drop", {31'd0, bus.rd_valid}, 32'd0);

        // Full clear with B requesting on the same edge and a second clear_start mid-sweep.
        bus.clear_start = 1'b1;
        bus.wb_req = 1'b1; bus.wb_addr = 9'h005; bus.wb_data = 8'h77;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (i == 0)   bus.clear_start = 1'b0;
            if (i == 100) bus.clear_start = 1'b1;
            if (i == 101) bus.clear_start = 1'b0;
            chk("clr_sweep", outs(), {9'd0, 6'b110000, i[8:0], 8'h00});
        end
        tick();
        chk("clr_done", outs(), {9'd0, 6'b001000, 9'h1FF, 8'h00});
        tick();
        chk("b_after_clear", outs(), {9'd0, 6'b100010, 9'h005, 8'h77});
        bus.wb_req = 1'b0;
        tick();
        chk("clr_no_more", {31'd0, bus.ram_write_en}, 32'd0);
        chk("mem_b_landed", {24'd0, mem[5]}, 32'h77);
        chk("mem_4_cleared", {24'd0, mem[4]}, 32'h00);
        chk("mem_1ff_cleared", {24'd0, mem[511]}, 32'h00);

        // Reset at cycle 200 of a sweep: immediate zeros, no done, memory partly cleared.
        write_a(9'h064, 8'h5A);
        write_a(9'h12C, 8'h5A);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 1; i < 200; i++) tick();
        chk("abort_at_199", outs(), {9'd0, 6'b110000, 9'd199, 8'h00});
        rst = 1'b1;
        tick();
        chk("abort_outs_zero", outs(), 32'd0);
        tick();
        chk("abort_mem_64", {24'd0, mem[100]}, 32'h00);
        chk("abort_mem_12c", {24'd0, mem[300]}, 32'h5A);
        rst = 1'b0;
`ifdef FRAMEBUF_CLEAR_ON_RESET_EN
        tick();
        chk("abort_resweep", outs(), {9'd0, 6'b110000, 9'd0, 8'h00});
        wait_done("abort_resweep_done");
`else
        seen_busy = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_busy |= bus.clear_busy | bus.ram_write_en;
            seen_done |= bus.clear_done;
        end
        chk("abort_no_busy", {31'd0, seen_busy}, 32'd0);
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
